// File: rtl/uart_pkg.sv
// Shared constants and types for the UART_TOP host controller.
// Status bit indices, FSM state encoding, read-select codes and reset configuration.
package uart_pkg;

  localparam int unsigned ST_TXRDY = 0;
  localparam int unsigned ST_RXRDY = 1;
  localparam int unsigned ST_PERR  = 2;
  localparam int unsigned ST_FERR  = 3;
  localparam int unsigned ST_OVF   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STAT  = 3'd1,
    SCAP  = 3'd2,
    RXRD  = 3'd3,
    RXCAP = 3'd4,
    TXWR  = 3'd5
  } state_t;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_DATA = 2'b01;
  localparam logic [1:0] RD_STAT = 2'b10;

  typedef struct packed {
    logic [3:0] baud;
    logic       eight;
    logic       pen;
    logic       ohel;
  } cfg_t;

  localparam logic [3:0] CFG_BAUD_RST  = 4'b1011;
  localparam logic       CFG_EIGHT_RST = 1'b1;
  localparam logic       CFG_PEN_RST   = 1'b1;
  localparam logic       CFG_OHEL_RST  = 1'b0;

  localparam cfg_t CFG_RST = '{baud: CFG_BAUD_RST, eight: CFG_EIGHT_RST,
                               pen: CFG_PEN_RST, ohel: CFG_OHEL_RST};

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-requester round-robin grant: the requester other than rr_last wins if it is valid.
module uart_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (rr_last) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// Host-side controller for UART_TOP: shared TX arbitration, interrupt/RX draining, safe config apply.
// UART_ERRCNT_EN adds saturating parity/framing error counters (o_perr_cnt, o_ferr_cnt).
//
// state | meaning
// IDLE  | apply pending config, or dispatch interrupt / TX request
// STAT  | status read strobe on the bus
// SCAP  | capture status, decide whether to drain RX data
// RXRD  | RX data read strobe on the bus
// RXCAP | capture RX byte into the output buffer
// TXWR  | grant one requester and write its byte
module uart_host_ctrl
  import uart_pkg::*;
`ifdef UART_ERRCNT_EN
  #(parameter int ERR_W = 8)
`endif
  (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_tx_valid,
  input  logic [7:0] i_tx_byte0,
  input  logic [7:0] i_tx_byte1,
  output logic [1:0] o_tx_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte,
  input  logic       i_rx_ready,
  input  logic       i_cfg_load,
  input  logic [3:0] i_cfg_baud,
  input  logic       i_cfg_eight,
  input  logic       i_cfg_pen,
  input  logic       i_cfg_ohel,
  output logic [3:0] o_uart_baud,
  output logic       o_uart_eight,
  output logic       o_uart_pen,
  output logic       o_uart_ohel,
  output logic       o_uart_write,
  output logic [7:0] o_uart_byte,
  output logic [1:0] o_uart_read,
  input  logic [7:0] i_uart_ds,
  input  logic       i_uart_intr,
  output logic       o_rx_drop
`ifdef UART_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] o_perr_cnt,
  output logic [ERR_W-1:0] o_ferr_cnt
`endif
);

  state_t     state, state_nxt;
  logic [1:0] read_nxt;
  logic [1:0] grant;
  logic       tx_free, rr_last, pending;
  logic       apply, tx_go, cap_stat, cap_data, drop;
  logic       tx_write;
  cfg_t       shadow, cfg;

  uart_rr_arb2 u_arb (
    .req     (i_tx_valid),
    .rr_last (rr_last),
    .grant   (grant)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    read_nxt  = RD_NONE;
    apply     = 1'b0;
    tx_go     = 1'b0;
    cap_stat  = 1'b0;
    cap_data  = 1'b0;
    case (state)
      IDLE: begin
        if (pending && tx_free && !o_rx_valid) apply = 1'b1;
        else if (i_uart_intr)                  state_nxt = STAT;
        else if (tx_free && (|i_tx_valid))     state_nxt = TXWR;
      end
      STAT:  state_nxt = SCAP;
      SCAP: begin
        cap_stat = 1'b1;
        if (i_uart_ds[ST_RXRDY] && !o_rx_valid) state_nxt = RXRD;
        else                                    state_nxt = IDLE;
      end
      RXRD:  state_nxt = RXCAP;
      RXCAP: begin
        cap_data  = 1'b1;
        state_nxt = IDLE;
      end
      TXWR: begin
        tx_go     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Read strobes come off the next state so they sit in STAT/RXRD and the bus is sampled one cycle later.
    if (state_nxt == STAT)      read_nxt = RD_STAT;
    else if (state_nxt == RXRD) read_nxt = RD_DATA;
  end

  assign drop     = cap_stat && i_uart_ds[ST_RXRDY] && o_rx_valid;
  assign tx_write = tx_go && (|grant);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_uart_read  <= RD_NONE;
      o_uart_write <= 1'b0;
      o_uart_byte  <= 8'h00;
      o_tx_ready   <= 2'b00;
      o_rx_drop    <= 1'b0;
      rr_last      <= 1'b1;
      tx_free      <= 1'b1;
    end else begin
      o_uart_read  <= read_nxt;
      o_uart_write <= tx_write;
      o_tx_ready   <= tx_go ? grant : 2'b00;
      o_rx_drop    <= drop;
      if (tx_write) begin
        o_uart_byte <= grant[1] ? i_tx_byte1 : i_tx_byte0;
        rr_last     <= grant[1];
      end
      if (tx_write)                            tx_free <= 1'b0;
      else if (cap_stat && i_uart_ds[ST_TXRDY]) tx_free <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rx_valid <= 1'b0;
      o_rx_byte  <= 8'h00;
    end else if (cap_data) begin
      o_rx_byte  <= i_uart_ds;
      o_rx_valid <= 1'b1;
    end else if (o_rx_valid && i_rx_ready) begin
      o_rx_valid <= 1'b0;
    end
  end

  // A load in the same cycle as an apply wins: the new shadow stays pending.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      shadow  <= CFG_RST;
      cfg     <= CFG_RST;
      pending <= 1'b0;
    end else begin
      if (i_cfg_load) shadow <= '{baud: i_cfg_baud, eight: i_cfg_eight,
                                  pen: i_cfg_pen, ohel: i_cfg_ohel};
      if (apply)      cfg <= shadow;
      pending <= i_cfg_load | (pending & ~apply);
    end
  end

  assign o_uart_baud  = cfg.baud;
  assign o_uart_eight = cfg.eight;
  assign o_uart_pen   = cfg.pen;
  assign o_uart_ohel  = cfg.ohel;

`ifdef UART_ERRCNT_EN
  logic [ERR_W-1:0] perr_cnt, ferr_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      perr_cnt <= '0;
      ferr_cnt <= '0;
    end else if (cap_stat) begin
      if (i_uart_ds[ST_PERR] && (perr_cnt != '1)) perr_cnt <= perr_cnt + 1'b1;
      if (i_uart_ds[ST_FERR] && (ferr_cnt != '1)) ferr_cnt <= ferr_cnt + 1'b1;
    end
  end

  assign o_perr_cnt = perr_cnt;
  assign o_ferr_cnt = ferr_cnt;
`endif

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: TX/RX scoreboards, UART_TOP bus model, config and reset checks.
// Counter checks run when UART_ERRCNT_EN is defined.
module tb_uart_host_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [1:0] i_tx_valid = 2'b00;
  logic [7:0] i_tx_byte0 = 8'h00, i_tx_byte1 = 8'h00;
  logic [1:0] o_tx_ready;
  logic       o_rx_valid;
  logic [7:0] o_rx_byte;
  logic       i_rx_ready = 1'b0;
  logic       i_cfg_load = 1'b0;
  logic [3:0] i_cfg_baud = 4'h0;
  logic       i_cfg_eight = 1'b0, i_cfg_pen = 1'b0, i_cfg_ohel = 1'b0;
  logic [3:0] o_uart_baud;
  logic       o_uart_eight, o_uart_pen, o_uart_ohel;
  logic       o_uart_write;
  logic [7:0] o_uart_byte;
  logic [1:0] o_uart_read;
  logic [7:0] i_uart_ds = 8'h00;
  logic       i_uart_intr = 1'b0;
  logic       o_rx_drop;
`ifdef UART_ERRCNT_EN
  logic [7:0] o_perr_cnt, o_ferr_cnt;
`endif

  uart_host_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_tx_valid   (i_tx_valid),
    .i_tx_byte0   (i_tx_byte0),
    .i_tx_byte1   (i_tx_byte1),
    .o_tx_ready   (o_tx_ready),
    .o_rx_valid   (o_rx_valid),
    .o_rx_byte    (o_rx_byte),
    .i_rx_ready   (i_rx_ready),
    .i_cfg_load   (i_cfg_load),
    .i_cfg_baud   (i_cfg_baud),
    .i_cfg_eight  (i_cfg_eight),
    .i_cfg_pen    (i_cfg_pen),
    .i_cfg_ohel   (i_cfg_ohel),
    .o_uart_baud  (o_uart_baud),
    .o_uart_eight (o_uart_eight),
    .o_uart_pen   (o_uart_pen),
    .o_uart_ohel  (o_uart_ohel),
    .o_uart_write (o_uart_write),
    .o_uart_byte  (o_uart_byte),
    .o_uart_read  (o_uart_read),
    .i_uart_ds    (i_uart_ds),
    .i_uart_intr  (i_uart_intr),
    .o_rx_drop    (o_rx_drop)
`ifdef UART_ERRCNT_EN
    ,
    .o_perr_cnt   (o_perr_cnt),
    .o_ferr_cnt   (o_ferr_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int vec_cnt = 0, err_cnt = 0;
  int wr_cnt = 0, drop_cnt = 0, cyc = 0;
  int rise_cyc0 = 0, last_wr_cyc = 0;

  logic [9:0] tx_exp[$];   // {grant, byte}
  logic [7:0] rx_exp[$];
  logic [7:0] req0_q[$], req1_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Requesters: present the head of their queue, advance on their tx_ready pulse.
  always @(negedge i_clk) begin
    if (o_tx_ready[0] && req0_q.size() > 0) void'(req0_q.pop_front());
    if (o_tx_ready[1] && req1_q.size() > 0) void'(req1_q.pop_front());
    if (!i_tx_valid[0] && req0_q.size() > 0) rise_cyc0 = cyc;
    i_tx_valid[0] = (req0_q.size() > 0);
    i_tx_valid[1] = (req1_q.size() > 0);
    if (req0_q.size() > 0) i_tx_byte0 = req0_q[0];
    if (req1_q.size() > 0) i_tx_byte1 = req1_q[0];
  end

  // Write scoreboard and drop counting.
  always @(negedge i_clk) begin
    logic [9:0] e;
    if (o_uart_write) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (tx_exp.size() == 0) begin
        check("tx_unexpected_write", {31'd0, o_uart_write}, 32'd0);
      end else begin
        e = tx_exp.pop_front();
        check("tx_byte", {24'd0, o_uart_byte}, {24'd0, e[7:0]});
        check("tx_ready", {30'd0, o_tx_ready}, {30'd0, e[9:8]});
      end
    end else if (o_tx_ready != 2'b00) begin
      check("tx_ready_stray", {30'd0, o_tx_ready}, 32'd0);
    end
    if (o_rx_drop) drop_cnt++;
  end

  // Raise the interrupt and play UART_TOP: status after the status strobe, data after the data strobe.
  task automatic intr_seq(input logic [7:0] stat, input logic [7:0] data, output int lat);
    logic prev_v, seen;
    seen   = 1'b0;
    lat    = -1;
    prev_v = o_rx_valid;
    i_uart_intr = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge i_clk);
      if (o_uart_read == 2'b10) begin
        i_uart_ds   = stat;
        i_uart_intr = 1'b0;
        seen        = 1'b1;
      end else if (o_uart_read == 2'b01) begin
        i_uart_ds = data;
      end
      if (o_rx_valid && !prev_v && lat < 0) lat = n;
      prev_v = o_rx_valid;
    end
    i_uart_intr = 1'b0;
    check("stat_read_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic rx_accept();
    @(negedge i_clk);
    check("rx_valid_before_accept", {31'd0, o_rx_valid}, 32'd1);
    if (rx_exp.size() == 0) check("rx_unexpected", {31'd0, o_rx_valid}, 32'd0);
    else                    check("rx_byte", {24'd0, o_rx_byte}, {24'd0, rx_exp.pop_front()});
    i_rx_ready = 1'b1;
    @(negedge i_clk);
    i_rx_ready = 1'b0;
    check("rx_valid_cleared", {31'd0, o_rx_valid}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    i_uart_intr = 1'b0;
    i_cfg_load = 1'b0;
    i_rx_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic cfg_load(input logic [3:0] baud, input logic eight, input logic pen, input logic ohel);
    @(negedge i_clk);
    i_cfg_load = 1'b1; i_cfg_baud = baud; i_cfg_eight = eight; i_cfg_pen = pen; i_cfg_ohel = ohel;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, w0;

    // Reset values while reset is held
    repeat (2) @(negedge i_clk);
    check("rst_tx_ready", {30'd0, o_tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);
    check("rst_rx_byte", {24'd0, o_rx_byte}, 32'd0);
    check("rst_write", {31'd0, o_uart_write}, 32'd0);
    check("rst_read", {30'd0, o_uart_read}, 32'd0);
    check("rst_drop", {31'd0, o_rx_drop}, 32'd0);
    check("rst_cfg", {25'd0, o_uart_baud, o_uart_eight, o_uart_pen, o_uart_ohel}, {25'd0, 4'b1011, 1'b1, 1'b1, 1'b0});
`ifdef UART_ERRCNT_EN
    check("rst_perr", {24'd0, o_perr_cnt}, 32'd0);
    check("rst_ferr", {24'd0, o_ferr_cnt}, 32'd0);
`endif
    @(negedge i_clk);
    i_rst = 1'b1;
    wait_cycles(2);

    // Single TX: latency 2, then no second write until TXRDY is read
    tx_exp.push_back({2'b01, 8'h6A});
    req0_q.push_back(8'h6A);
    for (int n = 0; n < 10 && wr_cnt < 1; n++) @(negedge i_clk);
    check("t1_write_count", wr_cnt, 1);
    check("t1_latency", last_wr_cyc - rise_cyc0, 2);
    tx_exp.push_back({2'b01, 8'h6B});
    req0_q.push_back(8'h6B);
    wait_cycles(10);
    check("t1_no_rewrite", wr_cnt, 1);
    intr_seq(8'h01, 8'h00, lat);
    wait_cycles(2);
    check("t1_write_after_txrdy", wr_cnt, 2);

    // Round robin from reset: grants 0,1,0,1 across three TXRDY interrupts
    do_reset();
    wait_cycles(1);
    w0 = wr_cnt;
    tx_exp.push_back({2'b01, 8'h10});
    tx_exp.push_back({2'b10, 8'h20});
    tx_exp.push_back({2'b01, 8'h11});
    tx_exp.push_back({2'b10, 8'h21});
    req0_q.push_back(8'h10); req0_q.push_back(8'h11);
    req1_q.push_back(8'h20); req1_q.push_back(8'h21);
    wait_cycles(6);
    for (int k = 0; k < 3; k++) intr_seq(8'h01, 8'h00, lat);
    wait_cycles(3);
    check("t2_write_count", wr_cnt - w0, 4);

    // RX drain: byte valid 5 cycles after the interrupt, cleared by handshake
    rx_exp.push_back(8'hA5);
    intr_seq(8'h02, 8'hA5, lat);
    check("t3_rx_latency", lat, 5);
    rx_accept();

    // Second RXRDY while the buffer is held: drop pulse, byte kept
    rx_exp.push_back(8'h3C);
    intr_seq(8'h02, 8'h3C, lat);
    check("t4_rx_latency", lat, 5);
    d0 = drop_cnt;
    intr_seq(8'h02, 8'h77, lat);
    check("t4_drop_pulse", drop_cnt - d0, 1);
    check("t4_rx_byte_kept", {24'd0, o_rx_byte}, 32'h3C);
    check("t4_rx_valid_kept", {31'd0, o_rx_valid}, 32'd1);
    rx_accept();

    // Config held while tx_free is low (last load wins), applied once TXRDY is read
    req1_q.push_back(8'h55);
    tx_exp.push_back({2'b10, 8'h55});
    cfg_load(4'b0010, 1'b1, 1'b1, 1'b1);
    cfg_load(4'b0100, 1'b0, 1'b0, 1'b1);
    wait_cycles(5);
    check("t5_cfg_held", {25'd0, o_uart_baud, o_uart_eight, o_uart_pen, o_uart_ohel}, {25'd0, 4'b1011, 1'b1, 1'b1, 1'b0});
    intr_seq(8'h01, 8'h00, lat);
    wait_cycles(2);
    check("t5_cfg_applied", {25'd0, o_uart_baud, o_uart_eight, o_uart_pen, o_uart_ohel}, {25'd0, 4'b0100, 1'b0, 1'b0, 1'b1});

    // Reset while the status strobe is on the bus
    @(negedge i_clk);
    i_uart_intr = 1'b1;
    @(negedge i_clk);
    check("t6_strobe_before_reset", {30'd0, o_uart_read}, 32'd2);
    i_rst = 1'b0;
    i_uart_intr = 1'b0;
    #1;
    check("t6_strobe_cleared", {30'd0, o_uart_read}, 32'd0);
    check("t6_cfg_reset", {28'd0, o_uart_baud}, 32'hB);
    wait_cycles(3);
    check("t6_no_strobe_in_reset", {29'd0, o_uart_read, o_uart_write}, 32'd0);
    i_rst = 1'b1;
    wait_cycles(2);

`ifdef UART_ERRCNT_EN
    // PERR counter saturates at all-ones; FERR untouched
    for (int k = 0; k < 10; k++) intr_seq(8'h04, 8'h00, lat);
    check("t7_perr_10", {24'd0, o_perr_cnt}, 32'd10);
    for (int k = 10; k < 300; k++) intr_seq(8'h04, 8'h00, lat);
    check("t7_perr_sat", {24'd0, o_perr_cnt}, 32'd255);
    check("t7_ferr_zero", {24'd0, o_ferr_cnt}, 32'd0);
    intr_seq(8'h08, 8'h00, lat);
    check("t7_ferr_one", {24'd0, o_ferr_cnt}, 32'd1);
`endif

    wait_cycles(2);
    check("tx_exp_drained", tx_exp.size(), 0);
    check("rx_exp_drained", rx_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_host_ctrl.md
# uart_host_ctrl

Host-side controller for the UART_TOP engine. Shares the single TX path between two byte requesters with round-robin arbitration. Services the UART interrupt by reading status and draining received bytes into a one-entry output buffer. Applies configuration (baud, eight, pen, ohel) only at safe points. Sits between the system fabric and UART_TOP's write/read/data/status pins.

## Interface

- ERR_W, 8, width of the saturating error counters.
- i_clk  in  1  system clock; everything is rising-edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_tx_valid  in  2  per-requester byte valid; requester 0 = bit 0.
- i_tx_byte0, i_tx_byte1  in  8  requester bytes, held stable while valid.
- o_tx_ready  out  2  one-hot accept pulse; the byte is taken in that cycle.
- o_rx_valid  out  1  received byte available.
- o_rx_byte  out  8  received byte.
- i_rx_ready  in  1  consumer accepts the byte when o_rx_valid and i_rx_ready are both high.
- i_cfg_load  in  1  pulse requesting a configuration change.
- i_cfg_baud  in  4  baud select; sampled with i_cfg_load.
- i_cfg_eight, i_cfg_pen, i_cfg_ohel  in  1  frame configuration; sampled with i_cfg_load.
- o_uart_baud  out  4  drives UART_TOP i_baud.
- o_uart_eight, o_uart_pen, o_uart_ohel  out  1  drive the matching UART_TOP inputs.
- o_uart_write  out  1  one-cycle write strobe to UART_TOP.
- o_uart_byte  out  8  write data.
- o_uart_read  out  2  read strobe: bit 0 = RX data, bit 1 = status; at most one bit high.
- i_uart_ds  in  8  UART_TOP data/status bus; valid the cycle after a read strobe.
- i_uart_intr  in  1  UART interrupt, level.
- o_rx_drop  out  1  one-cycle pulse when a received byte is left unread because the buffer is full.
- o_perr_cnt, o_ferr_cnt  out  ERR_W  error counters; present only with the macro.

## Operation

Status bit assignment on i_uart_ds: bit 0 TXRDY, bit 1 RXRDY, bit 2 PERR, bit 3 FERR, bit 4 OVF.

- tx_free flag: set by reset, cleared by o_uart_write, set when a captured status has TXRDY.
- rr_last: index of the last requester granted; reset value 1, so requester 0 wins first.

FSM states: IDLE, STAT, SCAP, RXRD, RXCAP, TXWR.

- IDLE, priority order:
  1. Pending configuration, with tx_free and !o_rx_valid: apply it (one cycle), stay in IDLE.
  2. i_uart_intr: go to STAT.
  3. tx_free and any i_tx_valid: go to TXWR.
- STAT: o_uart_read = 2'b10. Go to SCAP.
- SCAP: capture status.
  - RXRDY and !o_rx_valid: go to RXRD.
  - RXRDY and o_rx_valid: pulse o_rx_drop, go to IDLE.
  - Otherwise go to IDLE.
- RXRD: o_uart_read = 2'b01. Go to RXCAP.
- RXCAP: o_rx_byte ← i_uart_ds, set o_rx_valid. Go to IDLE.
- TXWR: grant goes to the requester other than rr_last if it is valid, else the valid one. In the same cycle: o_uart_write = 1, o_uart_byte = granted byte, o_tx_ready[g] = 1, rr_last ← g. Go to IDLE.
- Configuration: i_cfg_load captures the inputs into a shadow register and sets pending. A new load while pending overwrites the shadow (last wins). Applying copies shadow to o_uart_* and clears pending.
- o_rx_valid clears on the rx handshake. The handshake can happen in any state.

## Timing

- Reset values:
  - o_tx_ready = 0, o_rx_valid = 0, o_rx_byte = 0, o_uart_write = 0, o_uart_read = 0, o_rx_drop = 0.
  - o_uart_baud = 4'b1011, o_uart_eight = 1, o_uart_pen = 1, o_uart_ohel = 0.
  - Counters 0; state IDLE; tx_free = 1; pending = 0.
- Reset mid-operation aborts the current state immediately. No strobe is emitted after reset asserts.
- Strobe, tx_ready, rx_drop and o_uart_* outputs are registered.
- Latencies:
  - TX accept: 2 cycles from valid in IDLE with tx_free.
  - Interrupt to o_rx_valid: 5 cycles (IDLE, STAT, SCAP, RXRD, RXCAP).
- Interrupt and TX request together in IDLE: the interrupt wins.
- Simultaneous i_rx_ready handshake in RXCAP cannot occur, because o_rx_valid was low on entry.
- Counters saturate at all-ones. PERR and FERR each add 1 per captured status.

## Configuration

- UART_ERRCNT_EN defined: o_perr_cnt and o_ferr_cnt exist and count in SCAP.
- UART_ERRCNT_EN undefined: both ports and their counter logic are absent. All other behaviour is identical.

## Structure

- Shared package uart_pkg holds:
  - status bit index constants;
  - the FSM state enum;
  - the read-select constants RD_DATA = 2'b01 and RD_STAT = 2'b10;
  - the reset configuration constants.
- One sub-module, uart_rr_arb2: two-input round-robin grant with a rr_last input and a one-hot grant output.

## Test plan

- Reset release, then requester 0 valid with byte 8'h6A → o_uart_write pulse with o_uart_byte = 8'h6A 2 cycles later, o_tx_ready = 2'b01; no second write until a status with TXRDY is read.
- Both requesters held valid across three TXRDY interrupts → grants alternate 0, 1, 0.
- Interrupt with status 8'h02, then data 8'hA5 → o_rx_valid with 8'hA5 5 cycles after the interrupt; it clears on i_rx_ready.
- A second RXRDY while o_rx_valid is held and i_rx_ready = 0 → o_rx_drop pulse, o_rx_byte unchanged.
- i_cfg_load baud 4'b0100 while tx_free = 0 → o_uart_baud stays 4'b1011 until a TXRDY status is read, then becomes 4'b0100.
- With UART_ERRCNT_EN, 300 statuses with PERR set and ERR_W = 8 → o_perr_cnt saturates at 255, o_ferr_cnt = 0.
